// File: rtl/collision_pkg.sv
// Shared types and helpers for the pixel-overlap collision matrix.
package collision_pkg;

  localparam int MAX_OBJ = 8;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    COUNT    = 1'b1
  } state_e;

  // Pairs (i,j) with i<j are numbered i-major: (0,1)=0, (0,2)=1, ...
  function automatic int pair_index(input int i, input int j, input int n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/overlap_counter.sv
// Saturating per-pair overlap counter with clear and threshold compare.
module overlap_counter #(
  parameter int CNT_W      = 8,
  parameter int MIN_PIXELS = 1
) (
  input  logic clk,
  input  logic resetN,
  input  logic clr,
  input  logic inc,
  output logic at_thresh,
  output logic qual
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(MIN_PIXELS);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sum;

  // cnt_sum includes this cycle's pixel so a boundary-cycle overlap still counts.
  always_comb begin
    cnt_sum = cnt_q;
    if (inc && (cnt_q != CNT_MAX)) cnt_sum = cnt_q + CNT_W'(1);
    cnt_d = clr ? '0 : cnt_sum;
  end

  assign at_thresh = (cnt_sum >= MIN_V);
  assign qual      = inc & at_thresh;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/collision_matrix.sv
// N-object overlap detector: per-pair frame counts, published at each frame boundary.
module collision_matrix
  import collision_pkg::*;
#(
  parameter  int NUM_OBJ    = 4,
  localparam int NUM_PAIRS  = NUM_OBJ * (NUM_OBJ - 1) / 2,
  parameter  int MIN_PIXELS = 1,
  parameter  int CNT_W      = 8,
  parameter  int PIXEL_W    = 11
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic [PIXEL_W-1:0]   PixelX,
  input  logic [PIXEL_W-1:0]   PixelY,
  input  logic [NUM_OBJ-1:0]   draw,
  input  logic [NUM_PAIRS-1:0] pairEnable,
  output logic [NUM_PAIRS-1:0] collision,
  output logic [NUM_PAIRS-1:0] collisionRise,
  output logic                 frameValid,
  output logic                 hitValid,
  output logic [PIXEL_W-1:0]   firstHitX,
  output logic [PIXEL_W-1:0]   firstHitY,
  output logic [2:0]           firstHitPair
);

  state_e               state_q, state_d;
  logic [NUM_PAIRS-1:0] hit, at_thresh, qual;
  logic [NUM_PAIRS-1:0] collision_q, collision_d, rise_q, rise_d;
  logic                 frame_valid_q, frame_valid_d, hit_valid_q, hit_valid_d;
  logic [PIXEL_W-1:0]   first_x_q, first_x_d, first_y_q, first_y_d;
  logic [2:0]           first_pair_q, first_pair_d;
  logic                 fh_vld_q, fh_vld_d;
  logic [PIXEL_W-1:0]   fh_x_q, fh_x_d, fh_y_q, fh_y_d;
  logic [2:0]           fh_pair_q, fh_pair_d;
  logic                 counting, publish, cnt_clr, any_qual;
  logic [2:0]           low_k, cur_pair;
  logic [PIXEL_W-1:0]   cur_x, cur_y;

  assign counting = (state_q == COUNT);
  assign publish  = counting & startOfFrame;
  assign cnt_clr  = ~counting | startOfFrame;

  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_i
    for (genvar j = i + 1; j < NUM_OBJ; j++) begin : g_j
      localparam int K = pair_index(i, j, NUM_OBJ);
      assign hit[K] = draw[i] & draw[j] & pairEnable[K];
      overlap_counter #(
        .CNT_W      (CNT_W),
        .MIN_PIXELS (MIN_PIXELS)
      ) u_cnt (
        .clk       (clk),
        .resetN    (resetN),
        .clr       (cnt_clr),
        .inc       (hit[K] & counting),
        .at_thresh (at_thresh[K]),
        .qual      (qual[K])
      );
    end
  end

  always_comb begin
    low_k = '0;
    for (int k = NUM_PAIRS - 1; k >= 0; k--) begin
      if (qual[k]) low_k = 3'(k);
    end
  end

  assign any_qual = |qual;
  // An already-latched hit wins; otherwise this cycle's qualifying hit is the first.
  assign cur_x    = fh_vld_q ? fh_x_q    : PixelX;
  assign cur_y    = fh_vld_q ? fh_y_q    : PixelY;
  assign cur_pair = fh_vld_q ? fh_pair_q : low_k;

  always_comb begin
    state_d       = state_q;
    fh_vld_d      = fh_vld_q;
    fh_x_d        = fh_x_q;
    fh_y_d        = fh_y_q;
    fh_pair_d     = fh_pair_q;
    collision_d   = collision_q;
    rise_d        = rise_q;
    hit_valid_d   = hit_valid_q;
    first_x_d     = first_x_q;
    first_y_d     = first_y_q;
    first_pair_d  = first_pair_q;
    frame_valid_d = publish;

    if (!counting && startOfFrame) state_d = COUNT;

    if (!counting || publish) begin
      fh_vld_d = 1'b0;
    end else if (!fh_vld_q && any_qual) begin
      fh_vld_d  = 1'b1;
      fh_x_d    = PixelX;
      fh_y_d    = PixelY;
      fh_pair_d = low_k;
    end

    if (publish) begin
      collision_d = at_thresh;
      rise_d      = at_thresh & ~collision_q;
      hit_valid_d = |at_thresh;
      if (|at_thresh) begin
        first_x_d    = cur_x;
        first_y_d    = cur_y;
        first_pair_d = cur_pair;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= WAIT_SOF;
      fh_vld_q      <= 1'b0;
      fh_x_q        <= '0;
      fh_y_q        <= '0;
      fh_pair_q     <= '0;
      collision_q   <= '0;
      rise_q        <= '0;
      frame_valid_q <= 1'b0;
      hit_valid_q   <= 1'b0;
      first_x_q     <= '0;
      first_y_q     <= '0;
      first_pair_q  <= '0;
    end else begin
      state_q       <= state_d;
      fh_vld_q      <= fh_vld_d;
      fh_x_q        <= fh_x_d;
      fh_y_q        <= fh_y_d;
      fh_pair_q     <= fh_pair_d;
      collision_q   <= collision_d;
      rise_q        <= rise_d;
      frame_valid_q <= frame_valid_d;
      hit_valid_q   <= hit_valid_d;
      first_x_q     <= first_x_d;
      first_y_q     <= first_y_d;
      first_pair_q  <= first_pair_d;
    end
  end

  assign collision     = collision_q;
  assign collisionRise = rise_q;
  assign frameValid    = frame_valid_q;
  assign hitValid      = hit_valid_q;
  assign firstHitX     = first_x_q;
  assign firstHitY     = first_y_q;
  assign firstHitPair  = first_pair_q;

endmodule
